// File: rtl/composite_video_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : composite_video_encoder
//  Description : NTSC-style composite video generator. Free-running
//                horizontal/vertical counters drive a region decoder that
//                selects sync, colour burst, blanking or active picture.
//                In the active window the pixel's YIQ components are
//                modulated onto a 4x-subcarrier phase and summed into CVBS.
//  Ports       : clk_master    - 4x subcarrier sample clock
//                rst           - asynchronous active-high reset
//                y_in/i_in/q_in, pix_valid / pix_ready - pixel stream
//                mono          - suppress burst and chroma (latched per line)
//                underflow_clr - clears the sticky underflow flag
//                cvbs_out, luma_out, chroma_out, sync_n, frame_start,
//                underflow, h_cnt, v_cnt - registered outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module composite_video_encoder #(
    parameter int DATA_W       = 8,
    parameter int OUT_W        = 10,
    parameter int H_TOTAL      = 910,
    parameter int H_SYNC       = 67,
    parameter int BURST_START  = 76,
    parameter int BURST_LEN    = 36,
    parameter int H_ACT_START  = 164,
    parameter int H_ACT_LEN    = 720,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_LINES = 3,
    parameter int V_ACT_START  = 21,
    parameter int V_ACT_LEN    = 240,
    parameter int SYNC_LVL     = 16,
    parameter int BLANK_LVL    = 256,
    parameter int BLACK_LVL    = 276,
    parameter int BURST_AMP    = 64
) (
    input  logic              clk_master,
    input  logic              rst,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              mono,
    input  logic              underflow_clr,
    output logic [OUT_W-1:0]  cvbs_out,
    output logic [OUT_W-1:0]  luma_out,
    output logic [OUT_W-1:0]  chroma_out,
    output logic              sync_n,
    output logic              frame_start,
    output logic              underflow,
    output logic [10:0]       h_cnt,
    output logic [9:0]        v_cnt
);

    // Two guard bits so luma + chroma can neither wrap above nor below range.
    localparam int SW = OUT_W + 2;

    localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_H_SYNC  = 11'(H_SYNC);
    localparam logic [10:0] C_VS_END  = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] C_BURST_S = 11'(BURST_START);
    localparam logic [10:0] C_BURST_E = 11'(BURST_START + BURST_LEN);
    localparam logic [10:0] C_ACT_S   = 11'(H_ACT_START);
    localparam logic [10:0] C_ACT_E   = 11'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0]  C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_V_SYNC  = 10'(V_SYNC_LINES);
    localparam logic [9:0]  C_VA_S    = 10'(V_ACT_START);
    localparam logic [9:0]  C_VA_E    = 10'(V_ACT_START + V_ACT_LEN);

    localparam logic signed [SW-1:0] C_SYNC_S  = SW'(SYNC_LVL);
    localparam logic signed [SW-1:0] C_BLANK_S = SW'(BLANK_LVL);
    localparam logic signed [SW-1:0] C_BLACK_S = SW'(BLACK_LVL);
    localparam logic signed [SW-1:0] C_AMP_S   = SW'(BURST_AMP);
    localparam logic signed [SW-1:0] C_MID_S   = SW'(2 ** (OUT_W - 1));
    localparam logic signed [SW-1:0] C_MAX_S   = SW'(2 ** OUT_W - 1);

    logic [1:0]           r_ph;
    logic                 r_mono;

    logic                 w_h_wrap;
    logic [10:0]          w_h_next;
    logic [9:0]           w_v_next;
    logic                 w_active;
    logic                 w_nx_active;
    logic                 w_is_sync;
    logic                 w_uf_set;
    logic signed [SW-1:0] w_luma;
    logic signed [SW-1:0] w_chroma;
    logic signed [SW-1:0] w_y_ext;
    logic signed [SW-1:0] w_i_ext;
    logic signed [SW-1:0] w_q_ext;

    function automatic logic is_active(input logic [10:0] h, input logic [9:0] v);
        return (v >= C_VA_S) && (v < C_VA_E) && (h >= C_ACT_S) && (h < C_ACT_E);
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic signed [SW-1:0] x);
        if (x[SW-1])
            return '0;
        else if (x > C_MAX_S)
            return C_MAX_S[OUT_W-1:0];
        else
            return x[OUT_W-1:0];
    endfunction

    assign w_h_wrap    = (h_cnt == C_H_LAST);
    assign w_h_next    = w_h_wrap ? 11'd0 : h_cnt + 11'd1;
    assign w_v_next    = w_h_wrap ? ((v_cnt == C_V_LAST) ? 10'd0 : v_cnt + 10'd1) : v_cnt;
    assign w_active    = is_active(h_cnt, v_cnt);
    // pix_ready is registered from the next counter state so that it is high
    // exactly in the cycles whose registered counters sit in the window.
    assign w_nx_active = is_active(w_h_next, w_v_next);

    assign w_y_ext = SW'(y_in);
    assign w_i_ext = SW'($signed(i_in));
    assign w_q_ext = SW'($signed(q_in));

    always_comb begin
        w_luma    = C_BLANK_S;
        w_chroma  = '0;
        w_is_sync = 1'b0;
        w_uf_set  = 1'b0;
        if (v_cnt < C_V_SYNC) begin
            // Broad vertical sync pulse: serrated back to blank at line end.
            w_is_sync = (h_cnt < C_VS_END);
        end else if (h_cnt < C_H_SYNC) begin
            w_is_sync = 1'b1;
        end else if (h_cnt >= C_BURST_S && h_cnt < C_BURST_E) begin
            if (!r_mono) begin
                case (r_ph)
                    2'd1:    w_chroma = C_AMP_S;
                    2'd3:    w_chroma = -C_AMP_S;
                    default: w_chroma = '0;
                endcase
            end
        end else if (w_active) begin
            if (pix_valid) begin
                w_luma = C_BLACK_S + w_y_ext;
                if (!r_mono) begin
                    case (r_ph)
                        2'd0:    w_chroma = w_i_ext;
                        2'd1:    w_chroma = w_q_ext;
                        2'd2:    w_chroma = -w_i_ext;
                        default: w_chroma = -w_q_ext;
                    endcase
                end
            end else begin
                w_luma   = C_BLACK_S;
                w_uf_set = 1'b1;
            end
        end
        if (w_is_sync)
            w_luma = C_SYNC_S;
    end

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            r_ph        <= '0;
            r_mono      <= 1'b0;
            cvbs_out    <= C_BLANK_S[OUT_W-1:0];
            luma_out    <= C_BLANK_S[OUT_W-1:0];
            chroma_out  <= C_MID_S[OUT_W-1:0];
            sync_n      <= 1'b1;
            pix_ready   <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            h_cnt       <= w_h_next;
            v_cnt       <= w_v_next;
            // Phase never resyncs to the line; H_TOTAL mod 4 = 2 alternates it.
            r_ph        <= r_ph + 2'd1;
            if (h_cnt == 11'd0)
                r_mono <= mono;
            cvbs_out    <= sat(w_luma + w_chroma);
            luma_out    <= sat(w_luma);
            chroma_out  <= sat(C_MID_S + w_chroma);
            sync_n      <= ~w_is_sync;
            pix_ready   <= w_nx_active;
            frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
            // A new underflow takes priority over a simultaneous clear.
            underflow   <= w_uf_set | (underflow & ~underflow_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_composite_video_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_composite_video_encoder
//  Description : Scoreboard bench for composite_video_encoder. A behavioural
//                model predicts each output sample when stimulus is driven;
//                the prediction is popped and compared one cycle later.
//                Two extra instances cover saturation corner configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_composite_video_encoder;

    logic       clk_master = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] y_in = '0, i_in = '0, q_in = '0;
    logic       pix_valid = 1'b0, mono = 1'b0, underflow_clr = 1'b0;

    logic [9:0]  cvbs_out, luma_out, chroma_out;
    logic        sync_n, frame_start, underflow, pix_ready;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;

    logic [8:0]  b_cvbs, b_luma, b_chroma;
    logic        b_sync_n, b_fs, b_uf, b_pr;
    logic [10:0] b_h;
    logic [9:0]  b_v;
    logic [9:0]  c_cvbs, c_luma, c_chroma;
    logic        c_sync_n, c_fs, c_uf, c_pr;
    logic [10:0] c_h;
    logic [9:0]  c_v;

    always #5 clk_master = ~clk_master;

    composite_video_encoder dut (
        .clk_master(clk_master), .rst(rst), .y_in(y_in), .i_in(i_in), .q_in(q_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .mono(mono),
        .underflow_clr(underflow_clr), .cvbs_out(cvbs_out), .luma_out(luma_out),
        .chroma_out(chroma_out), .sync_n(sync_n), .frame_start(frame_start),
        .underflow(underflow), .h_cnt(h_cnt), .v_cnt(v_cnt)
    );

    composite_video_encoder #(.OUT_W(9)) dut_b (
        .clk_master(clk_master), .rst(rst), .y_in(y_in), .i_in(i_in), .q_in(q_in),
        .pix_valid(pix_valid), .pix_ready(b_pr), .mono(mono),
        .underflow_clr(underflow_clr), .cvbs_out(b_cvbs), .luma_out(b_luma),
        .chroma_out(b_chroma), .sync_n(b_sync_n), .frame_start(b_fs),
        .underflow(b_uf), .h_cnt(b_h), .v_cnt(b_v)
    );

    composite_video_encoder #(.BLACK_LVL(100)) dut_c (
        .clk_master(clk_master), .rst(rst), .y_in(y_in), .i_in(i_in), .q_in(q_in),
        .pix_valid(pix_valid), .pix_ready(c_pr), .mono(mono),
        .underflow_clr(underflow_clr), .cvbs_out(c_cvbs), .luma_out(c_luma),
        .chroma_out(c_chroma), .sync_n(c_sync_n), .frame_start(c_fs),
        .underflow(c_uf), .h_cnt(c_h), .v_cnt(c_v)
    );

    typedef struct {
        logic [9:0] cvbs;
        logic [9:0] luma;
        logic [9:0] chroma;
        logic       sync_n;
        logic       fs;
        logic       uf;
        int         h;
        int         v;
        int         ph;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mh, mv, mph;
    bit   mlat, muf;

    int burst_tab[4] = '{256, 320, 256, 192};
    int act_tab[4]   = '{396, 366, 356, 386};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at line %0d h %0d",
                     tag, got, got, exp, exp, mv, mh);
        end
    endtask

    function automatic bit m_active(int h, int v);
        return (v >= 21) && (v < 261) && (h >= 164) && (h < 884);
    endfunction

    // Reference prediction for the sample produced at counter position (mh, mv).
    function automatic exp_t model();
        exp_t e;
        int   lum, chr, cv, iv, qv;
        bit   sy, act, mono_line;
        lum = 256; chr = 0; sy = 0;
        act = m_active(mh, mv);
        mono_line = (mh == 0) ? mono : mlat;
        iv = int'($signed(i_in));
        qv = int'($signed(q_in));
        if (mv < 3) begin
            sy = (mh < 843);
        end else if (mh < 67) begin
            sy = 1;
        end else if (mh >= 76 && mh < 112) begin
            if (!mono_line) chr = (mph == 1) ? 64 : (mph == 3) ? -64 : 0;
        end else if (act) begin
            if (pix_valid) begin
                lum = 276 + int'(y_in);
                if (!mono_line)
                    chr = (mph == 0) ? iv : (mph == 1) ? qv : (mph == 2) ? -iv : -qv;
            end else begin
                lum = 276;
            end
        end
        if (sy) lum = 16;
        cv = lum + chr;
        if (cv < 0) cv = 0;
        if (cv > 1023) cv = 1023;
        e.cvbs   = 10'(cv);
        e.luma   = 10'(lum);
        e.chroma = 10'(512 + chr);
        e.sync_n = !sy;
        e.fs     = (mh == 0 && mv == 0);
        e.uf     = (act && !pix_valid) ? 1'b1 : (underflow_clr ? 1'b0 : muf);
        e.h = mh; e.v = mv; e.ph = mph;
        return e;
    endfunction

    task automatic drive();
        pix_valid     = 1'b1;
        underflow_clr = 1'b0;
        y_in = 8'($urandom);
        i_in = 8'($urandom);
        q_in = 8'($urandom);
        mono = (mv > 30) || (mv == 30 && mh >= 500);
        if (mv == 21 && mh >= 164 && mh < 168) begin
            y_in = 8'd100; i_in = 8'd20; q_in = 8'hF6;
        end
        if (mv == 22 && mh == 164) pix_valid = 1'b0;
        if (mv == 22 && mh == 170) begin pix_valid = 1'b0; underflow_clr = 1'b1; end
        if (mv == 23 && mh == 10) underflow_clr = 1'b1;
        if (mv == 24 && mh == 168) begin y_in = 8'd255; i_in = 8'd127; end
        if (mv == 24 && mh == 172) begin y_in = 8'd0;   i_in = 8'h80; end
        if (mv == 30 && mh == 600) begin y_in = 8'd0;   i_in = 8'd20; end
    endtask

    task automatic directed(input exp_t e);
        if (e.v == 0 && e.h == 0) begin
            chk("fs_first", frame_start, 1);
            chk("sync_first", sync_n, 0);
            chk("cvbs_first", cvbs_out, 16);
        end
        if (e.v == 0 && e.h == 3)   chk("vsync_h3", cvbs_out, 16);
        if (e.v == 0 && e.h == 843) begin
            chk("vsync_end", cvbs_out, 256);
            chk("vsync_end_sn", sync_n, 1);
        end
        if ((e.v == 10 || e.v == 11) && e.h >= 76 && e.h < 80)
            chk("burst", cvbs_out, burst_tab[e.ph]);
        if (e.v == 21 && e.h >= 164 && e.h < 168) begin
            chk("act_cvbs", cvbs_out, act_tab[e.ph]);
            chk("act_luma", luma_out, 376);
        end
        if (e.v == 22 && e.h == 164) begin
            chk("uf_cvbs", cvbs_out, 276);
            chk("uf_set", underflow, 1);
        end
        if (e.v == 22 && e.h == 169) chk("uf_held", underflow, 1);
        if (e.v == 22 && e.h == 170) chk("uf_set_wins", underflow, 1);
        if (e.v == 23 && e.h == 10)  chk("uf_clr", underflow, 0);
        if (e.v == 24 && e.h == 168) chk("sat_hi", b_cvbs, 511);
        if (e.v == 24 && e.h == 172) chk("sat_lo", c_cvbs, 0);
        if (e.v == 30 && e.h == 600) chk("mono_late", chroma_out, 532);
        if (e.v == 31 && e.h == 77) begin
            chk("mono_burst", cvbs_out, 256);
            chk("mono_burst_c", chroma_out, 512);
        end
        if (e.v == 31 && e.h == 300) chk("mono_chroma", chroma_out, 512);
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic step();
        exp_t e;
        drive();
        chk("cnt", {h_cnt, v_cnt, pix_ready}, {mh[10:0], mv[9:0], m_active(mh, mv)});
        sbq.push_back(model());
        @(posedge clk_master);
        #1;
        e = sbq.pop_front();
        chk("sb", {cvbs_out, luma_out, chroma_out, sync_n, frame_start, underflow},
                  {e.cvbs, e.luma, e.chroma, e.sync_n, e.fs, e.uf});
        directed(e);
        muf = e.uf;
        if (mh == 0) mlat = mono;
        mph = (mph + 1) % 4;
        if (mh == 909) begin
            mh = 0;
            mv = (mv == 261) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        @(negedge clk_master);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mph = 0; mlat = 0; muf = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, {h_cnt, v_cnt, cvbs_out, luma_out, chroma_out, sync_n, pix_ready,
                  frame_start, underflow},
                 {11'd0, 10'd0, 10'd256, 10'd256, 10'd512, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_master);
        #1;
        chk_reset_state("reset");
        @(negedge clk_master);
        rst = 1'b0;
        while (!(mv == 0 && mh == 400)) step();

        // Mid-line reset must take effect without waiting for a clock edge.
        rst = 1'b1;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk_master);
        #1;
        chk_reset_state("reset_hold");
        @(negedge clk_master);
        rst = 1'b0;
        model_reset();
        while (mv < 32) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
